// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// The optional same-cycle write bypass is enabled with REGFILE_BYPASS_EN.
package regfile_pkg;

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } clr_state_t;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_N_READ  = 2;
  localparam int DEF_N_WRITE = 2;

  // LSB of field idx inside a packed vector of w-bit fields
  function automatic int fld_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: walks the array once after reset or on request, zeroing one entry per edge.
//
// state    | meaning
// ST_RST   | reset held; pointer parked at first clearable entry
// ST_CLEAR | writing zero to entry[ptr] on each edge
// ST_READY | normal access, CLR_REQ restarts the sweep
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CLR_REQ,
  output logic              BUSY,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_ptr,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] FIRST = (ZERO_REG != 0) ? ADDR_W'(1) : '0;
  localparam logic [ADDR_W-1:0] LAST  = '1;

  clr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= ST_RST;
      ptr   <= FIRST;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      ST_RST: state_nxt = ST_CLEAR;
      ST_CLEAR: begin
        ptr_nxt = ptr + ADDR_W'(1);
        if (ptr == LAST) state_nxt = ST_READY;
      end
      ST_READY: begin
        if (CLR_REQ) begin
          state_nxt = ST_CLEAR;
          ptr_nxt   = FIRST;
        end
      end
      default: state_nxt = ST_RST;
    endcase
  end

  assign BUSY    = (state != ST_READY);
  assign clr_we  = (state == ST_CLEAR);
  assign ready   = (state == ST_READY);
  assign clr_ptr = ptr;

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised N-read / M-write register file with clear sequencer and optional zero entry.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_READ   = DEF_N_READ,
  parameter int N_WRITE  = DEF_N_WRITE,
  parameter int ZERO_REG = 1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      CLR_REQ,
  input  logic [N_READ*ADDR_W-1:0]  RA,
  output logic [N_READ*DATA_W-1:0]  RD,
  input  logic [N_WRITE-1:0]        WE,
  input  logic [N_WRITE*ADDR_W-1:0] WA,
  input  logic [N_WRITE*DATA_W-1:0] WD,
  output logic                      BUSY
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] ra  [N_READ];
  logic [DATA_W-1:0] rd  [N_READ];
  logic [ADDR_W-1:0] wa  [N_WRITE];
  logic [DATA_W-1:0] wd  [N_WRITE];

  logic              clr_we;
  logic              ready;
  logic [ADDR_W-1:0] clr_ptr;

  for (genvar r = 0; r < N_READ; r++) begin : g_rd
    assign ra[r] = RA[fld_lsb(r, ADDR_W) +: ADDR_W];
    assign RD[fld_lsb(r, DATA_W) +: DATA_W] = rd[r];
  end

  for (genvar w = 0; w < N_WRITE; w++) begin : g_wr
    assign wa[w] = WA[fld_lsb(w, ADDR_W) +: ADDR_W];
    assign wd[w] = WD[fld_lsb(w, DATA_W) +: DATA_W];
  end

  regfile_clear_fsm #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_clear_fsm (
    .CLK     (CLK),
    .RESET   (RESET),
    .CLR_REQ (CLR_REQ),
    .BUSY    (BUSY),
    .clr_we  (clr_we),
    .clr_ptr (clr_ptr),
    .ready   (ready)
  );

  // Array has no reset; contents are defined only once the clear sweep finishes.
  // Later loop iterations override earlier ones, so the highest write port wins.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[clr_ptr] <= '0;
    end else if (ready) begin
      for (int w = 0; w < N_WRITE; w++) begin
        if (WE[w] && !((ZERO_REG != 0) && (wa[w] == '0))) mem[wa[w]] <= wd[w];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < N_READ; r++) begin
      rd[r] = '0;
      if (ready && !((ZERO_REG != 0) && (ra[r] == '0))) begin
        rd[r] = mem[ra[r]];
`ifdef REGFILE_BYPASS_EN
        for (int w = 0; w < N_WRITE; w++) begin
          if (WE[w] && (wa[w] == ra[r])) rd[r] = wd[w];
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport at default parameters, against a flat array model.
module tb_regfile_multiport;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CLR_REQ;
  logic [9:0]  RA;
  logic [63:0] RD;
  logic [1:0]  WE;
  logic [9:0]  WA;
  logic [63:0] WD;
  logic        BUSY;

  logic [4:0]  ra [2];
  logic [4:0]  wa [2];
  logic [31:0] wd [2];
  logic [1:0]  we;
  logic [31:0] rd_o [2];

  logic [31:0] model [32];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cnt;

  assign RA = {ra[1], ra[0]};
  assign WA = {wa[1], wa[0]};
  assign WD = {wd[1], wd[0]};
  assign WE = we;
  assign rd_o[0] = RD[31:0];
  assign rd_o[1] = RD[63:32];

  regfile_multiport dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .CLR_REQ (CLR_REQ),
    .RA      (RA),
    .RD      (RD),
    .WE      (WE),
    .WA      (WA),
    .WD      (WD),
    .BUSY    (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Expected read value in READY given the currently driven write ports
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [31:0] v;
    if (a == 5'd0) return 32'h0;
    v = model[a];
`ifdef REGFILE_BYPASS_EN
    for (int w = 0; w < 2; w++)
      if (we[w] && wa[w] == a) v = wd[w];
`endif
    return v;
  endfunction

  task automatic commit_writes();
    for (int w = 0; w < 2; w++)
      if (we[w] && wa[w] != 5'd0) model[wa[w]] = wd[w];
  endtask

  task automatic read_all_zero(input string tag);
    we = 2'b00;
    for (int a = 0; a < 32; a++) begin
      ra[0] = 5'(a);
      ra[1] = 5'(31 - a);
      #1;
      chk({tag, "_p0"}, rd_o[0], 32'h0);
      chk({tag, "_p1"}, rd_o[1], 32'h0);
    end
  endtask

  task automatic count_busy(input int start);
    cnt = start;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (BUSY) cnt++;
      else break;
    end
  endtask

  initial begin
    RESET = 1'b1; CLR_REQ = 1'b0; we = 2'b00;
    ra[0] = 5'd9; ra[1] = 5'd17;
    wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
    #1;
    chk("reset_busy", 32'(BUSY), 32'd1);
    chk("reset_rd0", rd_o[0], 32'h0);
    chk("reset_rd1", rd_o[1], 32'h0);
    tick(); tick();

    // Reset release and initial clear
    RESET = 1'b0;
    count_busy(0);
    chk("init_clear_len", cnt, 32'd31);
    for (int a = 0; a < 32; a++) model[a] = 32'h0;
    read_all_zero("init_zero");

    // Dual write to the same address
    we = 2'b11; wa[0] = 5'd5; wa[1] = 5'd5;
    wd[0] = 32'hAAAA_AAAA; wd[1] = 32'h5555_5555; ra[0] = 5'd5;
    #1;
    chk("dual_same_cycle", rd_o[0], exp_rd(5'd5));
    commit_writes();
    tick();
    we = 2'b00; #1;
    chk("dual_after", rd_o[0], 32'h5555_5555);

    // Zero register
    we = 2'b11; wa[0] = 5'd0; wa[1] = 5'd0;
    wd[0] = 32'hDEAD_BEEF; wd[1] = 32'hDEAD_BEEF; ra[0] = 5'd0; ra[1] = 5'd0;
    #1;
    chk("zero_same_cycle", rd_o[0], 32'h0);
    tick();
    we = 2'b00; #1;
    chk("zero_after", rd_o[1], 32'h0);

    // Bypass / no-bypass visibility
    we = 2'b01; wa[0] = 5'd7; wd[0] = 32'h1234_5678; ra[0] = 5'd7;
    #1;
`ifdef REGFILE_BYPASS_EN
    chk("bypass_same_cycle", rd_o[0], 32'h1234_5678);
`else
    chk("nobypass_same_cycle", rd_o[0], 32'h0);
`endif
    commit_writes();
    tick();
    we = 2'b00; #1;
    chk("bypass_next_cycle", rd_o[0], 32'h1234_5678);

    // Randomised traffic against the model
    for (int i = 0; i < 300; i++) begin
      we = 2'($urandom_range(0, 3));
      for (int w = 0; w < 2; w++) begin
        wa[w] = (i % 2 == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        wd[w] = $urandom;
      end
      ra[0] = ($urandom_range(0, 1) == 0) ? wa[$urandom_range(0, 1)] : 5'($urandom_range(0, 31));
      ra[1] = 5'($urandom_range(0, 31));
      #1;
      chk("rand_rd0", rd_o[0], exp_rd(ra[0]));
      chk("rand_rd1", rd_o[1], exp_rd(ra[1]));
      commit_writes();
      tick();
      if (i % 50 == 0) chk("rand_busy", 32'(BUSY), 32'd0);
    end
    we = 2'b00;

    // Populate, then clear request with write on the same edge and writes while busy
    for (int a = 1; a < 32; a++) begin
      we = 2'b01; wa[0] = 5'(a); wd[0] = $urandom | 32'h1;
      commit_writes();
      tick();
    end
    we = 2'b00; ra[0] = 5'd31; #1;
    chk("populated_31", rd_o[0], model[31]);
    we = 2'b01; wa[0] = 5'd3; wd[0] = 32'hCAFE_F00D; ra[0] = 5'd3; CLR_REQ = 1'b1;
    #1;
    chk("clr_edge_rd", rd_o[0], exp_rd(5'd3));
    tick();
    CLR_REQ = 1'b0;
    chk("clr_busy_rise", 32'(BUSY), 32'd1);
    cnt = 1;
    for (int i = 0; i < 100; i++) begin
      we = 2'($urandom_range(1, 3));
      wa[0] = 5'($urandom_range(1, 31)); wa[1] = 5'($urandom_range(1, 31));
      wd[0] = $urandom | 32'h1; wd[1] = $urandom | 32'h1;
      ra[0] = wa[0];
      CLR_REQ = (i == 4);
      #1;
      if (i == 2) chk("clr_rd_during", rd_o[0], 32'h0);
      tick();
      if (BUSY) cnt++;
      else break;
    end
    CLR_REQ = 1'b0; we = 2'b00;
    chk("clr_req_len", cnt, 32'd31);
    for (int a = 0; a < 32; a++) model[a] = 32'h0;
    read_all_zero("clr_zero");

    // Reset in the middle of a clear
    for (int a = 1; a < 32; a += 3) begin
      we = 2'b10; wa[1] = 5'(a); wd[1] = 32'hF0F0_0000 | 32'(a);
      commit_writes();
      tick();
    end
    we = 2'b00;
    CLR_REQ = 1'b1;
    tick();
    CLR_REQ = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    RESET = 1'b1; ra[0] = 5'd20;
    #1;
    chk("midrst_busy", 32'(BUSY), 32'd1);
    chk("midrst_rd", rd_o[0], 32'h0);
    tick(); tick();
    chk("midrst_busy_held", 32'(BUSY), 32'd1);
    RESET = 1'b0;
    count_busy(0);
    chk("midrst_rerun_len", cnt, 32'd31);
    for (int a = 0; a < 32; a++) model[a] = 32'h0;
    read_all_zero("midrst_zero");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
